// File: rtl/elevator_display_pkg.sv
// Shared constants for the elevator display: direction codes, active-low
// 7-segment glyphs (bit 6 = segment A ... bit 0 = segment G) and the
// conversion FSM state type.
package elevator_display_pkg;

   // Direction encodings from the elevator controller (11 is shown as idle)
   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   // Non-numeric glyphs, active-low
   localparam logic [6:0] GLYPH_UP    = 7'b1000001;
   localparam logic [6:0] GLYPH_DOWN  = 7'b0001001;
   localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
   localparam logic [6:0] GLYPH_E     = 7'b0110000;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   // Decimal digits 0-9, active-low
   localparam logic [6:0] GLYPH_DIGIT [10] = '{
      7'b0000001,   // 0
      7'b1001111,   // 1
      7'b0010010,   // 2
      7'b0000110,   // 3
      7'b1001100,   // 4
      7'b0100100,   // 5
      7'b0100000,   // 6
      7'b0001111,   // 7
      7'b0000000,   // 8
      7'b0000100    // 9
   };

   // Conversion FSM state
   typedef logic [0:0] conv_state_t;
   localparam conv_state_t ST_IDLE = 1'b0;
   localparam conv_state_t ST_CONV = 1'b1;

   // BCD nibble to glyph; non-decimal codes render blank
   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      if (d > 4'd9) return GLYPH_BLANK;
      return GLYPH_DIGIT[d];
   endfunction

   // Direction code to glyph; the unused code 11 falls back to the idle dash
   function automatic logic [6:0] dir_glyph(input logic [1:0] d);
      case (d)
         DIR_UP:   return GLYPH_UP;
         DIR_DOWN: return GLYPH_DOWN;
         default:  return GLYPH_DASH;
      endcase
   endfunction

endpackage

// File: rtl/elevator_display_scan_bcd.sv
// Serial double-dabble binary-to-BCD converter. One add-3/shift step per
// clock, FLOOR_W steps per conversion. done pulses (combinationally) during
// the final step, while tens/units carry the finished result, so the caller
// can commit in that same edge. A start while converting restarts from the
// new value.
//
// Handshake: start is a one-cycle strobe accepted in any state; busy is high
// from the cycle after start until the cycle after the last step; done and
// tens/units are only meaningful together, in the cycle done is high.
module bcd_serial
   import elevator_display_pkg::*;
#(
   parameter int FLOOR_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [FLOOR_W-1:0] bin,
   output logic               busy,
   output logic               done,
   output logic [3:0]         tens,
   output logic [3:0]         units
);

   conv_state_t        state;
   logic [FLOOR_W-1:0] sr;
   logic [7:0]         acc;
   logic [7:0]         adj;
   logic [7:0]         acc_step;
   logic [2:0]         step_cnt;
   logic               last_step;

   assign last_step = (step_cnt == 3'(FLOOR_W - 1));
   assign busy      = (state == ST_CONV);
   assign done      = (state == ST_CONV) && last_step;
   assign tens      = acc_step[7:4];
   assign units     = acc_step[3:0];

   // One double-dabble step: correct each BCD nibble, then shift in the next bit
   always_comb begin
      adj = acc;
      if (acc[3:0] >= 4'd5) adj[3:0] = acc[3:0] + 4'd3;
      if (acc[7:4] >= 4'd5) adj[7:4] = acc[7:4] + 4'd3;
      acc_step = {adj[6:0], sr[FLOOR_W-1]};
   end

   // Conversion FSM; start has priority so the newest floor always wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         sr       <= '0;
         acc      <= '0;
         step_cnt <= '0;
      end else if (start) begin
         state    <= ST_CONV;
         sr       <= bin;
         acc      <= '0;
         step_cnt <= '0;
      end else if (state == ST_CONV) begin
         acc      <= acc_step;
         sr       <= sr << 1;
         step_cnt <= step_cnt + 3'd1;
         if (last_step) state <= ST_IDLE;
      end
   end

endmodule

// File: rtl/elevator_display_scan.sv
// Time-multiplexed common-anode 7-segment driver for the elevator displays.
// Digit 0 shows units, digit 1 tens (blank when zero), the top digit the
// direction glyph or a blinking E on fault. Segment and anode pins are
// registered and lag the scan counters by one cycle; the first cycle of each
// slot keeps every anode off to avoid ghosting between digits.
module elevator_display_scan
   import elevator_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int FLOOR_W    = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int BLINK_DIV  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FLOOR_W-1:0]    floor,
   input  logic [1:0]            dir,
   input  logic                  door_open,
   input  logic                  fault,
   input  logic                  load,
   output logic                  busy,
   output logic [6:0]            seven,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int SW  = $clog2(SCAN_DIV);
   localparam int DW  = $clog2(NUM_DIGITS);
   localparam int FCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

   logic [SW-1:0]         slot_cnt;
   logic [DW-1:0]         digit_idx;
   logic [FCW-1:0]        frame_cnt;
   logic                  blink_phase;
   logic                  slot_last;
   logic                  digit_last;
   logic                  frame_end;

   logic                  conv_done;
   logic [3:0]            conv_tens;
   logic [3:0]            conv_units;
   logic [3:0]            tens_q;
   logic [3:0]            units_q;

   logic                  floor_blank;
   logic [6:0]            glyph_next;
   logic [NUM_DIGITS-1:0] an_next;

   bcd_serial #(
      .FLOOR_W (FLOOR_W)
   ) u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (load),
      .bin   (floor),
      .busy  (busy),
      .done  (conv_done),
      .tens  (conv_tens),
      .units (conv_units)
   );

   // Committed floor digits; only a finished conversion replaces them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_q  <= '0;
         units_q <= '0;
      end else if (conv_done) begin
         tens_q  <= conv_tens;
         units_q <= conv_units;
      end
   end

   assign slot_last  = (slot_cnt == SW'(SCAN_DIV - 1));
   assign digit_last = (digit_idx == DW'(NUM_DIGITS - 1));
   assign frame_end  = slot_last && digit_last;

   // Slot counter and digit index; a frame ends when the index wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else if (slot_last) begin
         slot_cnt  <= '0;
         digit_idx <= digit_last ? '0 : digit_idx + DW'(1);
      end else begin
         slot_cnt  <= slot_cnt + SW'(1);
      end
   end

   // Blink phase flips after every BLINK_DIV complete frames
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (frame_cnt == FCW'(BLINK_DIV - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt   <= frame_cnt + FCW'(1);
         end
      end
   end

   // Glyph and anode pattern for the digit currently being scanned
   always_comb begin
      glyph_next  = GLYPH_BLANK;
      floor_blank = door_open && blink_phase;
      if (digit_idx == '0) begin
         glyph_next = floor_blank ? GLYPH_BLANK : digit_glyph(units_q);
      end else if (digit_idx == DW'(1)) begin
         glyph_next = (floor_blank || tens_q == 4'd0) ? GLYPH_BLANK : digit_glyph(tens_q);
      end else if (digit_last) begin
         if (fault) glyph_next = blink_phase ? GLYPH_BLANK : GLYPH_E;
         else       glyph_next = dir_glyph(dir);
      end
      an_next = (slot_cnt == '0) ? '1 : ~(AN_ONE << digit_idx);
   end

   // Registered pin drivers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seven <= GLYPH_BLANK;
         an    <= '1;
      end else begin
         seven <= glyph_next;
         an    <= an_next;
      end
   end

endmodule

// File: tb/tb_elevator_display_scan.sv
// Bench for elevator_display_scan: every clock edge a reference model works
// out the expected {busy, an, seven} from the time since reset and the
// history of loads, and queues it; a monitor on the falling edge pops and
// compares against the pins.
module tb_elevator_display_scan;

  localparam int ND = 4;
  localparam int FW = 6;
  localparam int SD = 4;
  localparam int BD = 1;
  localparam logic [11:0] RESET_EXP = {1'b0, 4'b1111, 7'b1111111};

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] floor;
  logic [1:0]    dir;
  logic          door_open;
  logic          fault;
  logic          load;
  logic          busy;
  logic [6:0]    seven;
  logic [ND-1:0] an;

  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  elevator_display_scan #(
    .NUM_DIGITS (ND),
    .FLOOR_W    (FW),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .floor     (floor),
    .dir       (dir),
    .door_open (door_open),
    .fault     (fault),
    .load      (load),
    .busy      (busy),
    .seven     (seven),
    .an        (an)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected decimal digit patterns
  function automatic logic [6:0] ref_digit(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // What the display should show for a digit position
  function automatic logic [6:0] ref_glyph(input int dig, input int val, input logic [1:0] d,
                                           input bit door, input bit flt, input bit blink);
    if (dig == 0) return (door && blink) ? 7'b1111111 : ref_digit(val % 10);
    if (dig == 1) return (door && blink) || (val / 10 == 0) ? 7'b1111111 : ref_digit(val / 10);
    if (dig == ND - 1) begin
      if (flt) return blink ? 7'b1111111 : 7'b0110000;
      if (d == 2'b01) return 7'b1000001;
      if (d == 2'b10) return 7'b0001001;
      return 7'b1111110;
    end
    return 7'b1111111;
  endfunction

  // Reference model: cycle count since reset release plus pending-load bookkeeping
  int cyc;
  bit pend_v;
  int pend_val;
  int pend_t;
  int com_val;
  always @(posedge clk or negedge rst_n) begin
    int  slot, dig, frame;
    bit  blink;
    logic [ND-1:0] av;
    logic [6:0]    sv;
    if (!rst_n) begin
      cyc     = 0;
      pend_v  = 0;
      com_val = 0;
    end else begin
      slot  = cyc % SD;
      dig   = (cyc / SD) % ND;
      frame = cyc / (SD * ND);
      blink = ((frame / BD) % 2) == 1;
      av    = (slot == 0) ? 4'b1111 : ~(4'b0001 << dig);
      sv    = ref_glyph(dig, com_val, dir, door_open, fault, blink);
      if (pend_v && cyc == pend_t + FW) begin
        com_val = pend_val;
        pend_v  = 0;
      end
      if (load) begin
        pend_v   = 1;
        pend_val = int'(floor);
        pend_t   = cyc;
      end
      exp_q.push_back({pend_v, av, sv});
      cyc++;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [11:0] got, exp_v;
    got = {busy, an, seven};
    if (!rst_n) begin
      exp_q.delete();
      exp_v = RESET_EXP;
    end else if (exp_q.size() == 0) begin
      exp_v = RESET_EXP;
    end else begin
      exp_v = exp_q.pop_front();
    end
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      if (n_err <= 25)
        $display("FAIL pins t=%0t got busy=%b an=%b seven=%b, expected busy=%b an=%b seven=%b",
                 $time, got[11], got[10:7], got[6:0], exp_v[11], exp_v[10:7], exp_v[6:0]);
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input int v);
    floor = FW'(v);
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    n_cmp++;
    if ({busy, an, seven} !== RESET_EXP) begin
      n_err++;
      $display("FAIL reset-state (%s) t=%0t got busy=%b an=%b seven=%b", tag, $time, busy, an, seven);
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < max_cyc) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait expired (%s) t=%0t busy still high after %0d cycles", tag, $time, max_cyc);
    end
  endtask

  // Stimulus
  initial begin
    rst_n     = 1'b0;
    floor     = '0;
    dir       = 2'b00;
    door_open = 1'b0;
    fault     = 1'b0;
    load      = 1'b0;
    tick(2);
    check_reset("power-on");
    tick(1);
    rst_n = 1'b1;
    tick(40);

    // Plain conversions, two digits then one
    do_load(42);
    wait_idle(FW + 2, "load 42");
    tick(30);
    do_load(7);
    wait_idle(FW + 2, "load 7");
    tick(30);

    // Restart two cycles in, then a load coinciding with the commit
    do_load(3);
    tick(1);
    do_load(12);
    wait_idle(FW + 2, "load 3 then 12");
    tick(30);
    do_load(25);
    tick(5);
    do_load(33);
    tick(30);

    // Direction glyphs
    dir = 2'b01; tick(40);
    dir = 2'b10; tick(40);
    dir = 2'b11; tick(40);
    dir = 2'b00;

    // Fault blink
    fault = 1'b1; tick(64);
    fault = 1'b0;

    // Door-open blink on floor 3 with a direction showing
    do_load(3);
    tick(10);
    dir = 2'b01;
    door_open = 1'b1; tick(64);
    door_open = 1'b0;

    // Randomised mix
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) door_open = ~door_open;
      if ($urandom_range(0, 31) == 0) fault = ~fault;
      if ($urandom_range(0, 7) == 0) begin
        floor = FW'($urandom_range(0, 63));
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      tick(1);
    end
    load = 1'b0;
    door_open = 1'b0;
    fault = 1'b0;
    tick(20);

    // Async reset in the middle of a conversion and of a slot
    do_load(55);
    tick(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("async mid-conversion");
    tick(2);
    rst_n = 1'b1;
    tick(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_display_scan.md
# elevator_display_scan

Parametrised, time-multiplexed 7-segment driver for the elevator cabin and hall displays. It shows the current floor as up to two decimal digits, a direction glyph, a door-open blink and a fault indication on a multi-digit common-anode display. It replaces the single-digit combinational decoder and sits between the elevator controller FSM and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, number of physical digits (legal 3..8)
- FLOOR_W, 4, floor code width (legal 1..6, so floor ≤ 63)
- SCAN_DIV, 100000, clock cycles per digit slot (≥ 2)
- BLINK_DIV, 32, scan frames per blink half-period (≥ 1)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- floor  in  FLOOR_W  binary floor number, sampled on load
- dir  in  2  direction: 00 idle, 01 up, 10 down, 11 treated as idle
- door_open  in  1  level; floor digits blink while high
- fault  in  1  level; direction digit shows E and blinks while high
- load  in  1  one-cycle strobe: capture floor and start conversion
- busy  out  1  BCD conversion in progress
- seven  out  7  segments, MSB = A … LSB = G, active-low (0 = lit)
- an  out  NUM_DIGITS  digit enables, active-low, at most one low

## Operation
- Conversion FSM, states IDLE and CONV. IDLE + load: capture floor into the shift register, clear BCD accumulators, go to CONV, busy = 1. CONV runs FLOOR_W serial double-dabble steps (add-3 to any BCD nibble ≥ 5, then shift left one). After the last step, commit tens/units to the display registers, return to IDLE, busy = 0.
- load during CONV restarts the conversion with the new floor. The latest value wins. Display registers keep the previous committed value until a conversion completes.
- dir, door_open and fault are sampled every cycle. They are not gated by load.
- Digit map:
  - digit 0 = units.
  - digit 1 = tens, blank when tens = 0.
  - digit NUM_DIGITS-1 = direction glyph.
  - All other digits blank.
- Glyphs:
  - Digits 0–9 use standard active-low patterns, for example 1 = 1001111, 2 = 0010010, 3 = 0000110.
  - Up = 1000001.
  - Down = 0001001.
  - Idle = 1111110 (dash).
  - E = 0110000.
  - Blank = 1111111.
- Blink: blink_phase toggles every BLINK_DIV complete frames. When blink_phase = 1, door_open blanks digits 0 and 1, and fault blanks the direction digit. When blink_phase = 0, fault shows E regardless of dir.
- Scan:
  - slot_cnt counts 0..SCAN_DIV-1.
  - At the terminal count, digit_idx advances and wraps from NUM_DIGITS-1 to 0.
  - A frame ends at the wrap.

## Timing
- Reset values:
  - seven = 1111111, an = all ones, busy = 0.
  - slot_cnt = 0, digit_idx = 0, blink_phase = 0, FSM = IDLE.
  - Committed floor = 0 (units shows 0, tens blank).
- seven and an are registered. They reflect digit_idx and slot_cnt of the previous cycle.
- Ghost guard: an is all ones for the first cycle of each slot (slot_cnt = 0), so each digit is lit for SCAN_DIV-1 cycles. In the first slot after reset release, the guard cycle still applies.
- Conversion latency: load in cycle t; busy = 1 from t+1; commit and busy = 0 at t+1+FLOOR_W. The new value appears on seven at the next registered output update in which that digit is selected.
- A load in the same cycle as the commit restarts the conversion; that commit still happens.
- Deasserting rst_n mid-conversion or mid-frame returns everything to the reset values immediately. A pending conversion is lost.

## Structure
- Shared package elevator_display_pkg holds:
  - dir encodings (DIR_IDLE, DIR_UP, DIR_DOWN);
  - the 7-bit glyph constants, including the digit array 0–9;
  - the FSM state type.
- One sub-module: bcd_serial (FLOOR_W-step double-dabble with start/busy/done, tens and units outputs).
- Scan, blink and glyph selection stay in the top module.

## Test plan
- Reset release with SCAN_DIV = 4, NUM_DIGITS = 4:
  - first slot has an = 1111 for one cycle, then 1110;
  - an cycles 1110 → 1101 → 1011 → 0111 every 4 cycles;
  - seven = 0000001 (0) on digit 0 and 1111110 on digit 3.
- Conversion, FLOOR_W = 6:
  - load floor = 42 → busy high for 6 cycles;
  - digit 1 = 1001100 (4), digit 0 = 0010010 (2).
  - Then floor = 7 → digit 1 blank.
- Restart on back-to-back load:
  - load 3, then load 12 two cycles later;
  - display never shows 3; it shows 1 and 2 after busy falls;
  - the old value is held throughout.
- Direction and fault, BLINK_DIV = 1:
  - dir = 01 → digit 3 = 1000001; dir = 10 → 0001001; dir = 11 → 1111110.
  - fault = 1 → digit 3 alternates 0110000 and 1111111 every frame.
- door_open = 1 with floor 3:
  - digits 0–1 alternate 0000110/blank per frame;
  - the direction digit is unaffected.
- Async reset asserted mid-CONV and mid-slot:
  - outputs go to 1111111 / all-ones in the same cycle, busy = 0;
  - after release the display shows 0.
